// File: rtl/alu_nibble_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_nibble_seq_pkg
//
// Shared definitions for the nibble-serial 16-bit ALU:
//   - FSM state encoding (IDLE / RUN / DONE)
//   - datapath geometry (WIDTH, NIBBLES, NIB_W)
//   - commonly used ALU_4bit function select codes
//
// No ports (package).
// -----------------------------------------------------------------------------
package alu_nibble_seq_pkg;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = 4;
    localparam int NIB_W   = WIDTH / NIBBLES;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Select codes in the slice encoding (active-high data).
    // Logic mode (m = 1)
    localparam logic [3:0] SEL_NOT_A   = 4'b0000;
    localparam logic [3:0] SEL_XOR     = 4'b0110;
    localparam logic [3:0] SEL_XNOR    = 4'b1001;
    localparam logic [3:0] SEL_AND     = 4'b1011;
    localparam logic [3:0] SEL_OR      = 4'b1110;
    // Arithmetic mode (m = 0); cin = 1 means "no carry in"
    localparam logic [3:0] SEL_A_PLUS_B  = 4'b1001;
    localparam logic [3:0] SEL_A_MINUS_B = 4'b0110;
    localparam logic [3:0] SEL_A_PLUS_A  = 4'b1100;
    localparam logic [3:0] SEL_A_MINUS_1 = 4'b1111;

    // Carry levels of the slice (carry-in and carry-out are active-low).
    localparam logic CARRY_NONE = 1'b1;
    localparam logic CARRY_SET  = 1'b0;

endpackage

// File: rtl/ALU_4bit.sv
// -----------------------------------------------------------------------------
// ALU_4bit
//
// Existing 4-bit ALU slice (181-style, active-high data, active-low carries).
// Each bit forms two terms from the select lines:
//   t1 = a | (b & s0) | (~b & s1)
//   t2 = (a & ~b & s2) | (a & b & s3)
// Arithmetic mode returns t1 + t2 (+1 when cn = 0); logic mode returns
// ~(t1 ^ t2), i.e. the sum bit with every internal carry forced, so the
// logic result never depends on cn. cn4 is produced in both modes.
//
// Ports:
//   a, b  in  4  operands
//   s     in  4  function select
//   m     in  1  1 = logic, 0 = arithmetic
//   cn    in  1  carry in, active-low
//   f     out 4  result
//   cn4   out 1  carry out, active-low
// -----------------------------------------------------------------------------
module ALU_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       cn,
    output logic [3:0] f,
    output logic       cn4
);

    logic [3:0] t1;
    logic [3:0] t2;
    logic [4:0] sum;

    assign t1  = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    assign t2  = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    assign sum = {1'b0, t1} + {1'b0, t2} + {4'b0000, ~cn};

    assign f   = m ? ~(t1 ^ t2) : sum[3:0];
    assign cn4 = ~sum[4];

endmodule

// File: rtl/alu_nibble_seq.sv
// -----------------------------------------------------------------------------
// alu_nibble_seq
//
// 16-bit ALU evaluated serially through a single ALU_4bit slice, one nibble
// per clock, least-significant nibble first. The slice carry-out of nibble k
// is registered and fed back as the carry-in of nibble k+1, so the result is
// identical to four slices cascaded combinationally.
//
// Handshake: start is sampled only in IDLE. When accepted, the operands and
// controls are captured, busy rises for the four RUN cycles, then done pulses
// for one cycle while f/cout present the new result. start seen in RUN or
// DONE is dropped, never queued. With start held high an operation is
// accepted every 6 cycles.
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst    in   1   synchronous active-high reset
//   start  in   1   request, sampled only in IDLE
//   a, b   in   16  operands
//   s      in   4   slice function select
//   m      in   1   1 = logic, 0 = arithmetic
//   cin    in   1   carry into nibble 0 (active-low, slice polarity)
//   f      out  16  registered result, held until the next completion
//   cout   out  1   registered carry out of nibble 3 (active-low)
//   busy   out  1   high in RUN
//   done   out  1   one-cycle completion pulse
// -----------------------------------------------------------------------------
module alu_nibble_seq
    import alu_nibble_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [3:0]        s,
    input  logic              m,
    input  logic              cin,
    output logic [WIDTH-1:0]  f,
    output logic              cout,
    output logic              busy,
    output logic              done
);

    state_t state;
    state_t state_next;

    // Captured operation
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       s_q;
    logic             m_q;

    // Serial datapath state
    logic [1:0]       idx;
    logic             carry_q;
    logic [11:0]      acc;      // nibbles 0..2; nibble 3 goes straight to f

    // Slice connections
    logic [NIB_W-1:0] slice_a;
    logic [NIB_W-1:0] slice_b;
    logic [NIB_W-1:0] slice_f;
    logic             slice_cout;

    assign slice_a = a_q[{idx, 2'b00} +: NIB_W];
    assign slice_b = b_q[{idx, 2'b00} +: NIB_W];

    ALU_4bit u_slice (
        .a   (slice_a),
        .b   (slice_b),
        .s   (s_q),
        .m   (m_q),
        .cn  (carry_q),
        .f   (slice_f),
        .cn4 (slice_cout)
    );

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start)        state_next = ST_RUN;
            ST_RUN:  if (idx == 2'd3)  state_next = ST_DONE;
            ST_DONE:                   state_next = ST_IDLE;
            default:                   state_next = ST_IDLE;
        endcase
    end

    // State register, datapath and registered outputs.
    // busy/done are decoded from state_next so they are flops that line up
    // exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            f       <= '0;
            cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            idx     <= 2'd0;
            carry_q <= 1'b0;
            acc     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            m_q     <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == ST_RUN);
            done  <= (state_next == ST_DONE);

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        s_q     <= s;
                        m_q     <= m;
                        carry_q <= cin;
                        idx     <= 2'd0;
                    end
                end
                ST_RUN: begin
                    carry_q <= slice_cout;
                    idx     <= idx + 2'd1;
                    case (idx)
                        2'd0: acc[3:0]  <= slice_f;
                        2'd1: acc[7:4]  <= slice_f;
                        2'd2: acc[11:8] <= slice_f;
                        default: begin
                            f    <= {slice_f, acc};
                            cout <= slice_cout;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_nibble_seq
//
// Self-checking bench for alu_nibble_seq. The reference model evaluates the
// whole 16-bit operation at once from the slice function table (arithmetic
// as a 17-bit sum, logic as a bitwise expression); every operation is timed
// cycle by cycle against the expected start-to-done schedule.
// -----------------------------------------------------------------------------
module tb_alu_nibble_seq;
    import alu_nibble_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  s;
    logic        m;
    logic        cin;
    logic [15:0] f;
    logic        cout;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [16:0] exp_q[$];     // {cout, f} per accepted operation
    logic [15:0] hold_f    = 16'h0000;
    logic        hold_cout = 1'b0;

    alu_nibble_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .s     (s),
        .m     (m),
        .cin   (cin),
        .f     (f),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Returns {cout, f}. Carries are active-low: cin = 1 adds nothing,
    // cout = 0 reports a carry out of bit 15. The carry is produced in both
    // modes; the logic result ignores it.
    function automatic logic [16:0] ref_alu(input logic [15:0] ra, input logic [15:0] rb,
                                            input logic [3:0] rs, input logic rm,
                                            input logic rcin);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] lf;
        logic [16:0] sum;
        case (rs)
            4'h0: begin x = ra;         y = 16'h0000;  end
            4'h1: begin x = ra | rb;    y = 16'h0000;  end
            4'h2: begin x = ra | ~rb;   y = 16'h0000;  end
            4'h3: begin x = 16'hFFFF;   y = 16'h0000;  end
            4'h4: begin x = ra;         y = ra & ~rb;  end
            4'h5: begin x = ra | rb;    y = ra & ~rb;  end
            4'h6: begin x = ra;         y = ~rb;       end
            4'h7: begin x = ra & ~rb;   y = 16'hFFFF;  end
            4'h8: begin x = ra;         y = ra & rb;   end
            4'h9: begin x = ra;         y = rb;        end
            4'hA: begin x = ra | ~rb;   y = ra & rb;   end
            4'hB: begin x = ra & rb;    y = 16'hFFFF;  end
            4'hC: begin x = ra;         y = ra;        end
            4'hD: begin x = ra | rb;    y = ra;        end
            4'hE: begin x = ra | ~rb;   y = ra;        end
            default: begin x = ra;      y = 16'hFFFF;  end
        endcase
        sum = {1'b0, x} + {1'b0, y} + {16'h0000, ~rcin};
        case (rs)
            4'h0: lf = ~ra;
            4'h1: lf = ~(ra | rb);
            4'h2: lf = ~ra & rb;
            4'h3: lf = 16'h0000;
            4'h4: lf = ~(ra & rb);
            4'h5: lf = ~rb;
            4'h6: lf = ra ^ rb;
            4'h7: lf = ra & ~rb;
            4'h8: lf = ~ra | rb;
            4'h9: lf = ~(ra ^ rb);
            4'hA: lf = rb;
            4'hB: lf = ra & rb;
            4'hC: lf = 16'hFFFF;
            4'hD: lf = ra | ~rb;
            4'hE: lf = ra | rb;
            default: lf = ra;
        endcase
        return {~sum[16], rm ? lf : sum[15:0]};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        a   = 16'($urandom);
        b   = 16'($urandom);
        s   = 4'($urandom_range(0, 15));
        m   = 1'($urandom_range(0, 1));
        cin = 1'($urandom_range(0, 1));
    endtask

    // One operation from acceptance to the IDLE cycle after done.
    //   scramble   : change operand/control inputs every cycle in flight
    //   poke       : hold start high through RUN and DONE (must be ignored)
    //   keep_start : leave start high at exit for back-to-back operation
    task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b,
                          input logic [3:0] op_s, input logic op_m, input logic op_cin,
                          input bit scramble, input bit poke, input bit keep_start);
        logic [16:0] exp;
        a = op_a; b = op_b; s = op_s; m = op_m; cin = op_cin;
        start = 1'b1;
        exp_q.push_back(ref_alu(op_a, op_b, op_s, op_m, op_cin));
        step();                                   // edge N: accepted
        check("busy_at_accept", busy, 1);
        check("done_at_accept", done, 0);
        check("f_held_at_accept", f, hold_f);
        start = poke;
        for (int k = 1; k <= 3; k++) begin
            if (scramble) scramble_inputs();
            step();                               // edges N+1..N+3
            check("busy_in_run", busy, 1);
            check("done_in_run", done, 0);
            check("f_held_in_run", f, hold_f);
            check("cout_held_in_run", cout, hold_cout);
        end
        if (scramble) scramble_inputs();
        step();                                   // edge N+4: result
        exp = exp_q.pop_front();
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 0);
        check("f_result", f, exp[15:0]);
        check("cout_result", cout, exp[16]);
        hold_f    = exp[15:0];
        hold_cout = exp[16];
        start = poke | keep_start;
        step();                                   // edge N+5: back to IDLE
        check("done_cleared", done, 0);
        check("busy_idle", busy, 0);
        check("f_held_after", f, hold_f);
        start = keep_start;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; start = 1'b0;
        a = 16'h0; b = 16'h0; s = 4'h0; m = 1'b0; cin = 1'b1;

        // Reset state, with start asserted to show reset wins
        step();
        start = 1'b1;
        step();
        check("rst_f", f, 16'h0000);
        check("rst_cout", cout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        start = 1'b0;
        rst = 1'b0;
        step();
        check("idle_busy", busy, 0);

        // Logic XOR
        run_op(16'h5A5A, 16'h0FF0, SEL_XOR, 1'b1, CARRY_NONE, 0, 0, 0);
        check("xor_const", f, 16'h55AA);

        // Full carry ripple: FFFF + 0001
        run_op(16'hFFFF, 16'h0001, SEL_A_PLUS_B, 1'b0, CARRY_NONE, 0, 0, 0);
        check("ripple_f_const", f, 16'h0000);
        check("ripple_cout_const", cout, CARRY_SET);

        // Operand change in flight
        run_op(16'h1234, 16'h1111, SEL_A_PLUS_B, 1'b0, CARRY_NONE, 1, 0, 0);
        check("inflight_const", f, 16'h2345);

        // Subtract with borrow, carry-in set
        run_op(16'h0003, 16'h0005, SEL_A_MINUS_B, 1'b0, CARRY_SET, 0, 0, 0);
        check("sub_const", f, 16'hFFFE);

        // Ignored start during RUN and DONE
        run_op(16'hABCD, 16'h0F0F, SEL_AND, 1'b1, CARRY_SET, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("no_second_busy", busy, 0);
            check("no_second_done", done, 0);
            check("f_unchanged_idle", f, hold_f);
        end

        // Reset abort at edge N+2
        a = 16'h7777; b = 16'h1111; s = SEL_A_PLUS_B; m = 1'b0; cin = CARRY_NONE;
        start = 1'b1;
        step();                                   // edge N
        start = 1'b0;
        step();                                   // edge N+1
        rst = 1'b1;
        step();                                   // edge N+2
        check("abort_busy", busy, 0);
        check("abort_f", f, 16'h0000);
        check("abort_cout", cout, 0);
        check("abort_done", done, 0);
        rst = 1'b0;
        hold_f = 16'h0000;
        hold_cout = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("abort_no_done", done, 0);
            check("abort_no_busy", busy, 0);
        end

        // Random regression, start held high back to back
        for (int i = 0; i < 1000; i++) begin
            run_op(16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1, 0, 1);
        end
        start = 1'b0;
        step();
        check("final_idle_busy", busy, 0);
        check("exp_q_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
